// File: rtl/alarm_program_ctrl.sv
// alarm_program_ctrl
// Alarm program-mode sequencer: loads the four digit counters, moves edit focus
// HT -> HU -> MT -> MU, forwards add/sub pulses to the focused digit, range-checks
// the edited time and commits it to the stored alarm.
// Optional build macro: PROG_TIMEOUT_EN enables an idle auto-abort after
// TIMEOUT_CYCLES button-free cycles in an edit state.
//
// Handshake: every button input is a 1-cycle pulse sampled on posedge i_clk. Every
// output is registered. o_cnt_add/o_cnt_sub, o_commit and o_err are single-cycle
// pulses; o_cnt_load_n is low for exactly one cycle. Same-cycle priority is
// prog > next > add > sub, and losing buttons are dropped.
// o_state exposes the FSM state for debug:
// 0=IDLE 1=LOAD 2=E_HT 3=E_HU 4=E_MT 5=E_MU 6=CHECK.
module alarm_program_ctrl #(
    parameter int WIDTH          = 4,
    parameter int HOUR_MAX       = 23,
    parameter int MIN_TENS_MAX   = 5,
    parameter int TIMEOUT_CYCLES = 30000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_prog_btn,
    input  logic               i_next_btn,
    input  logic               i_add_btn,
    input  logic               i_sub_btn,
    input  logic [4*WIDTH-1:0] i_edit_digits,
    output logic               o_cnt_load_n,
    output logic [3:0]         o_cnt_en,
    output logic               o_cnt_add,
    output logic               o_cnt_sub,
    output logic               o_prog_active,
    output logic [4*WIDTH-1:0] o_alarm_time,
    output logic               o_alarm_valid,
    output logic               o_commit,
    output logic               o_err,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_E_HT  = 3'd2,
        S_E_HU  = 3'd3,
        S_E_MT  = 3'd4,
        S_E_MU  = 3'd5,
        S_CHECK = 3'd6
    } state_t;

    localparam logic [4:0]       LP_HOUR_MAX = 5'(HOUR_MAX);
    localparam logic [WIDTH-1:0] LP_MT_MAX   = WIDTH'(MIN_TENS_MAX);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_cnt_load_n;
    logic [3:0]         r_cnt_en;
    logic               r_cnt_add;
    logic               r_cnt_sub;
    logic               r_prog_active;
    logic [4*WIDTH-1:0] r_alarm_time;
    logic               r_alarm_valid;
    logic               r_commit;
    logic               r_err;

    logic               w_add;
    logic               w_sub;
    logic               w_commit;
    logic               w_err;
    logic               w_timeout;
    logic               w_range_ok;
    logic [3:0]         w_en_next;
    logic [4:0]         w_hours;
    logic [WIDTH-1:0]   w_ht;
    logic [WIDTH-1:0]   w_hu;
    logic [WIDTH-1:0]   w_mt;

    assign w_ht = i_edit_digits[4*WIDTH-1:3*WIDTH];
    assign w_hu = i_edit_digits[3*WIDTH-1:2*WIDTH];
    assign w_mt = i_edit_digits[2*WIDTH-1:WIDTH];

    // Hours are formed at 5 bits, so out-of-range tens digits wrap rather than widen.
    assign w_hours    = 5'(w_ht) * 5'd10 + 5'(w_hu);
    assign w_range_ok = (w_hours <= LP_HOUR_MAX) && (w_mt <= LP_MT_MAX);

`ifdef PROG_TIMEOUT_EN
    localparam int              LP_CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LP_CW-1:0] LP_TO_LAST = LP_CW'(TIMEOUT_CYCLES - 1);

    logic [LP_CW-1:0] r_idle_cnt;
    logic             w_is_edit;
    logic             w_any_btn;

    assign w_is_edit = (r_state == S_E_HT) || (r_state == S_E_HU) ||
                       (r_state == S_E_MT) || (r_state == S_E_MU);
    assign w_any_btn = i_prog_btn | i_next_btn | i_add_btn | i_sub_btn;
    assign w_timeout = w_is_edit && !w_any_btn && (r_idle_cnt == LP_TO_LAST);

    // Count consecutive button-free cycles spent in an edit state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle_cnt <= '0;
        end else if (!w_is_edit || w_any_btn || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    // Without the timeout option edit states hold until a button arrives.
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-pulse decode with fixed button priority.
    always_comb begin
        w_next_state = r_state;
        w_add        = 1'b0;
        w_sub        = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_prog_btn) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                w_next_state = S_E_HT;
            end
            S_E_HT, S_E_HU, S_E_MT, S_E_MU: begin
                if (i_prog_btn) begin
                    w_next_state = S_IDLE;
                end else if (i_next_btn) begin
                    case (r_state)
                        S_E_HT:  w_next_state = S_E_HU;
                        S_E_HU:  w_next_state = S_E_MT;
                        S_E_MT:  w_next_state = S_E_MU;
                        default: w_next_state = S_CHECK;
                    endcase
                end else if (i_add_btn) begin
                    w_add = 1'b1;
                end else if (i_sub_btn) begin
                    w_sub = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_err        = 1'b1;
                end
            end
            S_CHECK: begin
                if (w_range_ok) begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_err        = 1'b1;
                    w_next_state = S_E_HT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // One-hot digit enable for the state being entered.
    always_comb begin
        w_en_next = 4'b0000;
        case (w_next_state)
            S_E_HT:  w_en_next = 4'b1000;
            S_E_HU:  w_en_next = 4'b0100;
            S_E_MT:  w_en_next = 4'b0010;
            S_E_MU:  w_en_next = 4'b0001;
            default: w_en_next = 4'b0000;
        endcase
    end

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt_load_n  <= 1'b1;
            r_cnt_en      <= 4'b0000;
            r_cnt_add     <= 1'b0;
            r_cnt_sub     <= 1'b0;
            r_prog_active <= 1'b0;
            r_alarm_time  <= '0;
            r_alarm_valid <= 1'b0;
            r_commit      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cnt_load_n  <= (w_next_state != S_LOAD);
            r_cnt_en      <= w_en_next;
            r_cnt_add     <= w_add;
            r_cnt_sub     <= w_sub;
            r_prog_active <= (w_next_state != S_IDLE);
            r_commit      <= w_commit;
            r_err         <= w_err;
            if (w_commit) begin
                r_alarm_time  <= i_edit_digits;
                r_alarm_valid <= 1'b1;
            end
        end
    end

    assign o_cnt_load_n  = r_cnt_load_n;
    assign o_cnt_en      = r_cnt_en;
    assign o_cnt_add     = r_cnt_add;
    assign o_cnt_sub     = r_cnt_sub;
    assign o_prog_active = r_prog_active;
    assign o_alarm_time  = r_alarm_time;
    assign o_alarm_valid = r_alarm_valid;
    assign o_commit      = r_commit;
    assign o_err         = r_err;
    assign o_state       = r_state;

endmodule
